// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC and runs a single-outstanding
// request/response handshake with instruction memory, then registers inst/PC for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] PC,
    output logic        inst_valid
);

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        inst_valid_q, inst_valid_d;

    logic        slot_free;
    logic        load;
    logic [31:0] load_inst;
    logic [31:0] redirect_pc_aligned;
    logic [31:0] fetch_pc_inc;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Request is combinational from state so a refetch can issue the cycle after a redirect.
    assign imem_req   = (state_q == REQ);
    assign imem_addr  = fetch_pc_q;
    assign inst       = inst_q;
    assign PC         = pc_q;
    assign inst_valid = inst_valid_q;

    always_comb begin
        state_d             = state_q;
        fetch_pc_d          = fetch_pc_q;
        hold_inst_d         = hold_inst_q;
        load                = 1'b0;
        load_inst           = hold_inst_q;
        slot_free           = !inst_valid_q || !stall;
        redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
        fetch_pc_inc        = fetch_pc_q + 32'(INST_BYTES);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ready) begin
                    state_d = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (redirect_valid) begin
                        state_d = REQ;
                    end else if (slot_free) begin
                        load       = 1'b1;
                        load_inst  = imem_rdata;
                        fetch_pc_d = fetch_pc_inc;
                        state_d    = REQ;
                    end else begin
                        hold_inst_d = imem_rdata;
                        state_d     = HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            // Stale response must drain before a new request may be issued.
            DROP: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_d = REQ;
                end else if (slot_free) begin
                    load       = 1'b1;
                    load_inst  = hold_inst_q;
                    fetch_pc_d = fetch_pc_inc;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: redirect beats load beats consume.
    always_comb begin
        inst_d       = inst_q;
        pc_d         = pc_q;
        inst_valid_d = inst_valid_q;
        if (redirect_valid) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
            pc_d         = 32'h0;
        end else if (load) begin
            inst_valid_d = 1'b1;
            inst_d       = load_inst;
            pc_d         = fetch_pc_q;
        end else if (inst_valid_q && !stall) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            hold_inst_q  <= 32'h0;
            inst_q       <= NOP_INST;
            pc_q         <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            hold_inst_q  <= hold_inst_d;
            inst_q       <= inst_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

endmodule
